axi_lite_sys_bridge: RTL

AXI4-Lite slave to sys-bus master bridge. It sits directly upstream of the PL register block and drives its sys_addr/sys_wdata/sys_wen/sys_ren strobes. It collects the sys_ack/sys_err/sys_rdata reply and converts it into AXI B/R responses. One transaction is outstanding at a time, and a timeout guards against slaves that never acknowledge.

---
 rtl/axi_lite_sys_pkg.sv | 15 +
 rtl/axi_lite_cap_reg.sv | 35 +++
 rtl/axi_lite_sys_bridge.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/axi_lite_sys_pkg.sv
// rtl/axi_lite_sys_pkg.sv - shared constants for the AXI4-Lite to sys-bus bridge
package axi_lite_sys_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_BRESP = 3'd3;
    localparam logic [2:0] ST_RRESP = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TO_CNT_W = 8;

endpackage

// File: rtl/axi_lite_cap_reg.sv
// rtl/axi_lite_cap_reg.sv - one-entry valid/ready capture register
module axi_lite_cap_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_clear,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    // i_clear is only raised while full, so it never races a load
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/axi_lite_sys_bridge.sv
// rtl/axi_lite_sys_bridge.sv - AXI4-Lite slave to sys-bus master, one transaction outstanding
module axi_lite_sys_bridge
    import axi_lite_sys_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [AW-1:0]   s_awaddr_i,
    input  logic            s_awvalid_i,
    output logic            s_awready_o,
    input  logic [DW-1:0]   s_wdata_i,
    input  logic [DW/8-1:0] s_wstrb_i,
    input  logic            s_wvalid_i,
    output logic            s_wready_o,
    output logic [1:0]      s_bresp_o,
    output logic            s_bvalid_o,
    input  logic            s_bready_i,
    input  logic [AW-1:0]   s_araddr_i,
    input  logic            s_arvalid_i,
    output logic            s_arready_o,
    output logic [DW-1:0]   s_rdata_o,
    output logic [1:0]      s_rresp_o,
    output logic            s_rvalid_o,
    input  logic            s_rready_i,
    output logic [AW-1:0]   sys_addr_o,
    output logic [DW-1:0]   sys_wdata_o,
    output logic            sys_wen_o,
    output logic            sys_ren_o,
    input  logic [DW-1:0]   sys_rdata_i,
    input  logic            sys_ack_i,
    input  logic            sys_err_i
);

    localparam int SW = DW / 8;
    localparam logic [TO_CNT_W-1:0] LP_TIMEOUT = TO_CNT_W'(TIMEOUT);

    logic                w_aw_full, w_w_full, w_ar_full;
    logic [AW-1:0]       w_awaddr, w_araddr;
    logic [DW+SW-1:0]    w_wbuf;
    logic                w_wr_pend, w_rd_pend, w_pick_rd, w_start;
    logic                w_clr_wr, w_clr_rd, w_strb_ok, w_ack_ok;
    logic [TO_CNT_W-1:0] w_cnt_inc;

    logic [2:0]          r_state;
    logic                r_rr_last;
    logic                r_is_read;
    logic [1:0]          r_resp;
    logic [DW-1:0]       r_rdata;
    logic [AW-1:0]       r_sys_addr;
    logic [DW-1:0]       r_sys_wdata;
    logic [TO_CNT_W-1:0] r_cnt;

    axi_lite_cap_reg #(.W(AW)) u_aw (
        .clk_i(clk_i), .rstn_i(rstn_i), .i_valid(s_awvalid_i), .o_ready(s_awready_o),
        .i_data(s_awaddr_i), .i_clear(w_clr_wr), .o_full(w_aw_full), .o_data(w_awaddr)
    );

    axi_lite_cap_reg #(.W(DW + SW)) u_w (
        .clk_i(clk_i), .rstn_i(rstn_i), .i_valid(s_wvalid_i), .o_ready(s_wready_o),
        .i_data({s_wstrb_i, s_wdata_i}), .i_clear(w_clr_wr), .o_full(w_w_full), .o_data(w_wbuf)
    );

    axi_lite_cap_reg #(.W(AW)) u_ar (
        .clk_i(clk_i), .rstn_i(rstn_i), .i_valid(s_arvalid_i), .o_ready(s_arready_o),
        .i_data(s_araddr_i), .i_clear(w_clr_rd), .o_full(w_ar_full), .o_data(w_araddr)
    );

    // r_rr_last = 1 means the last completed transaction was a read
    assign w_wr_pend = w_aw_full && w_w_full;
    assign w_rd_pend = w_ar_full;
    assign w_pick_rd = w_rd_pend && (!w_wr_pend || !r_rr_last);
    assign w_start   = (r_state == ST_IDLE) && (w_wr_pend || w_rd_pend);
    assign w_clr_wr  = w_start && !w_pick_rd;
    assign w_clr_rd  = w_start && w_pick_rd;
    assign w_strb_ok = &w_wbuf[DW+SW-1:DW];
    assign w_ack_ok  = sys_ack_i && !sys_err_i;
    assign w_cnt_inc = r_cnt + TO_CNT_W'(1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_rr_last   <= 1'b1;
            r_is_read   <= 1'b0;
            r_resp      <= RESP_OKAY;
            r_rdata     <= '0;
            r_sys_addr  <= '0;
            r_sys_wdata <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_is_read <= w_pick_rd;
                        if (!w_pick_rd && !w_strb_ok) begin
                            r_resp  <= RESP_SLVERR;
                            r_state <= ST_BRESP;
                        end else begin
                            r_sys_addr <= w_pick_rd ? w_araddr : w_awaddr;
                            if (!w_pick_rd) begin
                                r_sys_wdata <= w_wbuf[DW-1:0];
                            end
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (sys_ack_i || sys_err_i || (w_cnt_inc == LP_TIMEOUT)) begin
                        r_resp  <= w_ack_ok ? RESP_OKAY : RESP_SLVERR;
                        r_state <= r_is_read ? ST_RRESP : ST_BRESP;
                        if (r_is_read) begin
                            r_rdata <= w_ack_ok ? sys_rdata_i : '0;
                        end
                    end
                end
                ST_BRESP: begin
                    if (s_bready_i) begin
                        r_rr_last <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RRESP: begin
                    if (s_rready_i) begin
                        r_rr_last <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sys_addr_o  = r_sys_addr;
    assign sys_wdata_o = r_sys_wdata;
    assign sys_wen_o   = (r_state == ST_ISSUE) && !r_is_read;
    assign sys_ren_o   = (r_state == ST_ISSUE) && r_is_read;
    assign s_bvalid_o  = (r_state == ST_BRESP);
    assign s_rvalid_o  = (r_state == ST_RRESP);
    assign s_bresp_o   = r_resp;
    assign s_rresp_o   = r_resp;
    assign s_rdata_o   = r_rdata;

endmodule
